jt51_opacc: RTL and testbench

// Output accumulator sitting directly downstream of the operator pipeline. Receives one

---
 rtl/jt51_opacc_if.sv | 25 ++
 rtl/jt51_opacc.sv | 131 +++++++++++++
 tb/tb_jt51_opacc.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/jt51_opacc_if.sv
// Slot-stream and stereo-output bundle between the operator pipeline,
// the output accumulator and whatever consumes the mixed samples.
interface jt51_opacc_if #(
    parameter int OUTW = 16
);
    logic                    cen;
    logic                    zero;
    logic signed [13:0]      op_in;
    logic        [2:0]       con_in;
    logic        [1:0]       rl_in;
    logic signed [OUTW-1:0]  left;
    logic signed [OUTW-1:0]  right;
    logic                    sample;
    logic        [4:0]       slot;

    modport master (
        output cen, zero, op_in, con_in, rl_in,
        input  left, right, sample, slot
    );

    modport slave (
        input  cen, zero, op_in, con_in, rl_in,
        output left, right, sample, slot
    );
endinterface

// File: rtl/jt51_opacc.sv
// Per-frame stereo mixer: sums carrier operators into L/R accumulators and
// emits saturated samples with a one-clock strobe at every frame boundary.
module jt51_opacc #(
    parameter int ACCW = 18,
    parameter int OUTW = 16
) (
    input  logic           clk,
    input  logic           rst,
    jt51_opacc_if.slave    bus
);
    localparam logic signed [ACCW-1:0] SAT_HI = {{(ACCW-OUTW+1){1'b0}}, {(OUTW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_LO = {{(ACCW-OUTW+1){1'b1}}, {(OUTW-1){1'b0}}};
    localparam logic signed [ACCW-1:0] ACC_ZERO = {ACCW{1'b0}};

    logic        [4:0]      slot_q,   slot_d;
    logic signed [ACCW-1:0] acc_l_q,  acc_l_d;
    logic signed [ACCW-1:0] acc_r_q,  acc_r_d;
    logic signed [OUTW-1:0] left_q,   left_d;
    logic signed [OUTW-1:0] right_q,  right_d;
    logic                   sample_q, sample_d;
    logic                   valid_q,  valid_d;

    logic        [4:0]      cur_s;
    logic                   carrier_s;
    logic signed [ACCW-1:0] c_s;
    logic signed [ACCW-1:0] cl_s;
    logic signed [ACCW-1:0] cr_s;

    // Group 3 (C2) always sounds; the others depend on how far up CON goes.
    function automatic logic is_carrier(input logic [1:0] grp, input logic [2:0] con);
        logic r;
        case (grp)
            2'd0:    r = (con == 3'd7);
            2'd1:    r = (con >= 3'd5);
            2'd2:    r = (con >= 3'd4);
            2'd3:    r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic signed [ACCW-1:0] sext(input logic signed [13:0] v);
        return {{(ACCW-14){v[13]}}, v};
    endfunction

    function automatic logic signed [OUTW-1:0] sat(input logic signed [ACCW-1:0] x);
        logic signed [OUTW-1:0] r;
        if (x > SAT_HI) begin
            r = SAT_HI[OUTW-1:0];
        end else if (x < SAT_LO) begin
            r = SAT_LO[OUTW-1:0];
        end else begin
            r = x[OUTW-1:0];
        end
        return r;
    endfunction

    // Contribution of the current slot; zero forces slot 0 regardless of the counter.
    always_comb begin
        cur_s     = bus.zero ? 5'd0 : slot_q;
        carrier_s = is_carrier(cur_s[4:3], bus.con_in);
        if (carrier_s) begin
            c_s = sext(bus.op_in);
        end else begin
            c_s = ACC_ZERO;
        end
        cl_s = bus.rl_in[0] ? c_s : ACC_ZERO;
        cr_s = bus.rl_in[1] ? c_s : ACC_ZERO;
    end

    // Next-state: accumulate mid-frame, publish and restart on a frame boundary.
    always_comb begin
        slot_d   = slot_q;
        acc_l_d  = acc_l_q;
        acc_r_d  = acc_r_q;
        left_d   = left_q;
        right_d  = right_q;
        sample_d = 1'b0;
        valid_d  = valid_q;
        if (bus.cen) begin
            if (bus.zero) begin
                slot_d  = 5'd1;
                acc_l_d = cl_s;
                acc_r_d = cr_s;
                valid_d = 1'b1;
                // The very first boundary after reset only opens a frame.
                if (valid_q) begin
                    left_d   = sat(acc_l_q);
                    right_d  = sat(acc_r_q);
                    sample_d = 1'b1;
                end else begin
                    left_d   = left_q;
                    right_d  = right_q;
                    sample_d = 1'b0;
                end
            end else begin
                slot_d  = slot_q + 5'd1;
                acc_l_d = acc_l_q + cl_s;
                acc_r_d = acc_r_q + cr_s;
            end
        end else begin
            slot_d = slot_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_q   <= 5'd0;
            acc_l_q  <= ACC_ZERO;
            acc_r_q  <= ACC_ZERO;
            left_q   <= {OUTW{1'b0}};
            right_q  <= {OUTW{1'b0}};
            sample_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            slot_q   <= slot_d;
            acc_l_q  <= acc_l_d;
            acc_r_q  <= acc_r_d;
            left_q   <= left_d;
            right_q  <= right_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.left   = left_q;
    assign bus.right  = right_q;
    assign bus.sample = sample_q;
    assign bus.slot   = slot_q;
endmodule

// File: tb/tb_jt51_opacc.sv
// Scoreboard bench: two accumulator widths driven from one slot stream,
// expected samples derived from whole-frame sums.
module tb_jt51_opacc;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic              cen = 1'b0;
    logic              zero = 1'b0;
    logic signed [13:0] op_in = 14'sd0;
    logic [2:0]        con_in = 3'd0;
    logic [1:0]        rl_in = 2'd0;

    jt51_opacc_if #(.OUTW(16)) b18 ();
    jt51_opacc_if #(.OUTW(16)) b19 ();

    assign b18.cen = cen;   assign b19.cen = cen;
    assign b18.zero = zero; assign b19.zero = zero;
    assign b18.op_in = op_in; assign b19.op_in = op_in;
    assign b18.con_in = con_in; assign b19.con_in = con_in;
    assign b18.rl_in = rl_in; assign b19.rl_in = rl_in;

    jt51_opacc #(.ACCW(18), .OUTW(16)) dut18 (.clk(clk), .rst(rst), .bus(b18.slave));
    jt51_opacc #(.ACCW(19), .OUTW(16)) dut19 (.clk(clk), .rst(rst), .bus(b19.slave));

    typedef struct {
        int l18;
        int r18;
        int l19;
        int r19;
    } exp_t;

    exp_t exp_q[$];
    exp_t pend;
    bit   pend_valid = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   pushed = 0;
    int   strobes = 0;
    bit   done = 1'b0;

    int        ops [32];
    logic [2:0] cons [8];
    logic [1:0] rls [8];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: reduce a signed value modulo 2^w, then clamp to 16 bits.
    function automatic int wrap(input longint v, input int w);
        longint m = longint'(1) << w;
        longint r = ((v % m) + m) % m;
        if (r >= m / 2) r = r - m;
        return int'(r);
    endfunction

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int frame_sum(input int n, input int side);
        int s = 0;
        for (int k = 0; k < n; k++) begin
            int  grp = k / 8;
            int  ch  = k % 8;
            bit  carrier;
            carrier = (grp == 3) || (grp == 2 && cons[ch] >= 3'd4) ||
                      (grp == 1 && cons[ch] >= 3'd5) || (grp == 0 && cons[ch] == 3'd7);
            if (carrier && rls[ch][side]) s += ops[k];
        end
        return s;
    endfunction

    function automatic exp_t make_exp(input int n);
        exp_t e;
        int sl = frame_sum(n, 0);
        int sr = frame_sum(n, 1);
        e.l18 = sat16(wrap(sl, 18));
        e.r18 = sat16(wrap(sr, 18));
        e.l19 = sat16(wrap(sl, 19));
        e.r19 = sat16(wrap(sr, 19));
        return e;
    endfunction

    task automatic drive_slot(input bit z, input int op, input logic [2:0] con,
                              input logic [1:0] rl, input int gap);
        cen = 1'b1; zero = z; op_in = 14'(op); con_in = con; rl_in = rl;
        @(negedge clk);
        cen = 1'b0; zero = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic run_frame(input int n, input int hold_at);
        logic signed [15:0] lsave;
        if (pend_valid) begin
            exp_q.push_back(pend);
            pushed++;
        end
        for (int s = 0; s < n; s++) begin
            drive_slot(s == 0, ops[s], cons[s % 8], rls[s % 8], $urandom_range(0, 2));
            if (s == hold_at) begin
                lsave = b18.left;
                repeat (10) @(negedge clk);
                check("hold_slot", b18.slot, (s + 1) % 32);
                check("hold_left", b18.left, lsave);
                check("hold_sample", b18.sample, 0);
            end
        end
        pend = make_exp(n);
        pend_valid = 1'b1;
    endtask

    task automatic randomize_frame();
        for (int k = 0; k < 32; k++) ops[k] = $urandom_range(0, 8000) - 4000;
        for (int c = 0; c < 8; c++) begin
            cons[c] = 3'($urandom_range(0, 7));
            rls[c]  = 2'($urandom_range(0, 3));
        end
    endtask

    // Monitor: every strobe consumes one expected sample.
    initial begin
        exp_t e;
        logic prev_s = 1'b0;
        while (!done) begin
            @(posedge clk);
            #1;
            if (b18.sample || b19.sample) begin
                strobes++;
                check("strobe_width", prev_s, 0);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_strobe: got strobe expected none");
                end else begin
                    e = exp_q.pop_front();
                    check("left18", b18.left, e.l18);
                    check("right18", b18.right, e.r18);
                    check("left19", b19.left, e.l19);
                    check("right19", b19.right, e.r19);
                    check("sample18", b18.sample, 1);
                    check("sample19", b19.sample, 1);
                end
            end
            prev_s = b18.sample;
        end
    end

    initial begin
        int wait_cnt;
        repeat (3) @(negedge clk);
        check("rst_left", b18.left, 0);
        check("rst_right", b19.right, 0);
        check("rst_sample", b18.sample, 0);
        check("rst_slot", b18.slot, 0);
        rst = 1'b1;
        @(negedge clk);

        // All operators sounding at 100: 32 x 100.
        for (int k = 0; k < 32; k++) ops[k] = 100;
        for (int c = 0; c < 8; c++) begin cons[c] = 3'd7; rls[c] = 2'd3; end
        run_frame(32, -1);
        run_frame(32, -1);

        // CON=0: only the C2 slots count.
        for (int k = 0; k < 32; k++) ops[k] = (k >= 24) ? 1000 : 500;
        for (int c = 0; c < 8; c++) begin cons[c] = 3'd0; rls[c] = 2'd3; end
        run_frame(32, -1);

        // Left-only channel 0 with CON=4.
        randomize_frame();
        for (int c = 0; c < 8; c++) rls[c] = 2'd0;
        cons[0] = 3'd4; rls[0] = 2'd1;
        ops[16] = -2000; ops[24] = -2000;
        run_frame(32, -1);

        // Full scale both polarities: 19-bit saturates, 18-bit wraps.
        for (int c = 0; c < 8; c++) begin cons[c] = 3'd7; rls[c] = 2'd3; end
        for (int k = 0; k < 32; k++) ops[k] = 8191;
        run_frame(32, -1);
        for (int k = 0; k < 32; k++) ops[k] = -8192;
        run_frame(32, -1);

        // Random frames, one stalled mid-frame, one closed early.
        for (int f = 0; f < 6; f++) begin
            randomize_frame();
            run_frame((f == 4) ? 20 : 32, (f == 2) ? 10 : -1);
        end

        // Reset at slot 17 discards the partial frame.
        randomize_frame();
        run_frame(17, -1);
        rst = 1'b0;
        #1;
        check("midrst_left", b18.left, 0);
        check("midrst_right19", b19.right, 0);
        check("midrst_slot", b18.slot, 0);
        check("midrst_sample", b18.sample, 0);
        pend_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        randomize_frame();
        run_frame(32, -1);
        randomize_frame();
        run_frame(32, -1);

        // Close the last frame and let the monitor drain.
        if (pend_valid) begin
            exp_q.push_back(pend);
            pushed++;
        end
        drive_slot(1'b1, 0, 3'd0, 2'd0, 0);
        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        repeat (2) @(negedge clk);
        check("drain", exp_q.size(), 0);
        check("strobe_count", strobes, pushed);
        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
